branch_predictor: RTL and testbench

- Direct-mapped branch history table with a branch target buffer. Fetch queries it with a PC and gets a registered taken/not-taken prediction and target one cycle later.
- Execute feeds back resolved outcomes: the branch decision from the branch compare logic, plus the computed target.
- Sits between fetch (predict port) and execute (update port), closing the loop on the existing branch resolution path.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_table.sv | 70 +++++++
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter type and saturating update for the branch predictor
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;

  function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = bp_ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) nxt = bp_ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_table.sv
// rtl/bp_table.sv - direct-mapped entry storage: valid/tag/target/counter per entry
// Lookup and update sides each get a combinational read; one write port, flush clears valids.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = $clog2(ENTRIES),
  parameter int TAG_BITS = 30 - IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic [IDX_BITS-1:0] i_lk_idx,
  output logic                o_lk_valid,
  output logic [TAG_BITS-1:0] o_lk_tag,
  output logic [31:0]         o_lk_target,
  output bp_ctr_t             o_lk_ctr,
  input  logic [IDX_BITS-1:0] i_up_idx,
  output logic                o_up_valid,
  output logic [TAG_BITS-1:0] o_up_tag,
  output logic [31:0]         o_up_target,
  output bp_ctr_t             o_up_ctr,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0] i_wr_tag,
  input  logic [31:0]         i_wr_target,
  input  bp_ctr_t             i_wr_ctr
);

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  bp_ctr_t             r_ctr    [ENTRIES];

  // Flush only drops valid bits; counters survive so a re-allocated entry is unaffected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= BP_CTR_RESET;
      end
    end else if (i_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_ctr[i_wr_idx]   <= i_wr_ctr;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en && !i_flush) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end

  assign o_lk_valid  = r_valid[i_lk_idx];
  assign o_lk_tag    = r_tag[i_lk_idx];
  assign o_lk_target = r_target[i_lk_idx];
  assign o_lk_ctr    = r_ctr[i_lk_idx];

  assign o_up_valid  = r_valid[i_up_idx];
  assign o_up_tag    = r_tag[i_up_idx];
  assign o_up_target = r_target[i_up_idx];
  assign o_up_ctr    = r_ctr[i_up_idx];

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT + BTB: registered predict port, resolved-branch update port
// Lookups read pre-update table contents, so a same-cycle update is seen from the next fetch on.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic [IDX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0] w_lk_tag_req;
  logic                w_lk_valid;
  logic [TAG_BITS-1:0] w_lk_tag;
  logic [31:0]         w_lk_target;
  bp_ctr_t             w_lk_ctr;
  logic                w_lk_hit;
  logic                w_lk_taken;

  logic [IDX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0] w_up_tag_req;
  logic                w_up_valid;
  logic [TAG_BITS-1:0] w_up_tag;
  logic [31:0]         w_up_target;
  bp_ctr_t             w_up_ctr;
  logic                w_up_hit;

  logic                w_wr_en;
  logic [31:0]         w_wr_target;
  bp_ctr_t             w_wr_ctr;

  logic                r_pred_valid;
  logic                r_pred_hit;
  logic                r_pred_taken;
  logic [31:0]         r_pred_target;

  assign w_lk_idx     = fetch_pc[IDX_BITS+1:2];
  assign w_lk_tag_req = fetch_pc[31:IDX_BITS+2];
  assign w_up_idx     = upd_pc[IDX_BITS+1:2];
  assign w_up_tag_req = upd_pc[31:IDX_BITS+2];

  bp_table #(
    .ENTRIES  (ENTRIES),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_lk_idx    (w_lk_idx),
    .o_lk_valid  (w_lk_valid),
    .o_lk_tag    (w_lk_tag),
    .o_lk_target (w_lk_target),
    .o_lk_ctr    (w_lk_ctr),
    .i_up_idx    (w_up_idx),
    .o_up_valid  (w_up_valid),
    .o_up_tag    (w_up_tag),
    .o_up_target (w_up_target),
    .o_up_ctr    (w_up_ctr),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_up_idx),
    .i_wr_tag    (w_up_tag_req),
    .i_wr_target (w_wr_target),
    .i_wr_ctr    (w_wr_ctr)
  );

  assign w_lk_hit   = w_lk_valid && (w_lk_tag == w_lk_tag_req);
  assign w_lk_taken = w_lk_hit && w_lk_ctr[1];

  // A not-taken miss leaves the table alone; a taken miss allocates at weakly-taken.
  assign w_up_hit    = w_up_valid && (w_up_tag == w_up_tag_req);
  assign w_wr_en     = upd_valid && !flush && (w_up_hit || upd_taken);
  assign w_wr_ctr    = w_up_hit ? ctr_next(w_up_ctr, upd_taken) : WT;
  assign w_wr_target = upd_taken ? upd_target : w_up_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= 32'd0;
    end else begin
      r_pred_valid  <= fetch_valid;
      r_pred_hit    <= fetch_valid && w_lk_hit;
      r_pred_taken  <= fetch_valid && w_lk_taken;
      r_pred_target <= (fetch_valid && w_lk_taken) ? w_lk_target : 32'd0;
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_hit    = r_pred_hit;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vectors, async reset sequence and randomized model check
module tb_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int IDX_BITS = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .pred_valid  (pred_valid),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        fl;
    logic        ev;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  int checks;
  int failures;

  // Reference model: one record per entry, counter held as an integer 0..3.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic        m_ev, m_eh, m_et;
  logic [31:0] m_etgt;

  function automatic vec_t mk(logic fv, logic [31:0] fpc, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic fl,
                              logic ev, logic eh, logic et, logic [31:0] etgt);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.fl = fl;
    v.ev = ev; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_predict(input logic fv, input logic [31:0] pc);
    int unsigned idx;
    int unsigned tg;
    idx    = (pc >> 2) % ENTRIES;
    tg     = pc >> (IDX_BITS + 2);
    m_ev   = fv;
    m_eh   = fv && m_valid[idx] && (m_tag[idx] == tg);
    m_et   = m_eh && (m_ctr[idx] >= 2);
    m_etgt = m_et ? m_target[idx] : 32'd0;
  endtask

  task automatic model_update(input logic uv, input logic [31:0] pc, input logic ut,
                              input logic [31:0] tgt, input logic fl);
    int unsigned idx;
    int unsigned tg;
    idx = (pc >> 2) % ENTRIES;
    tg  = pc >> (IDX_BITS + 2);
    if (fl) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      if (m_valid[idx] && m_tag[idx] == tg) begin
        if (ut) begin
          m_ctr[idx]    = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          m_target[idx] = tgt;
        end else begin
          m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
      end else if (ut) begin
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = tg;
        m_target[idx] = tgt;
        m_ctr[idx]    = 2;
      end
    end
  endtask

  task automatic run_cycle(input vec_t v);
    fetch_valid = v.fv;
    fetch_pc    = v.fpc;
    upd_valid   = v.uv;
    upd_pc      = v.upc;
    upd_taken   = v.ut;
    upd_target  = v.utgt;
    flush       = v.fl;
    model_predict(v.fv, v.fpc);
    @(posedge clk);
    #1;
    model_update(v.uv, v.upc, v.ut, v.utgt, v.fl);
  endtask

  task automatic idle_inputs();
    fetch_valid = 1'b0; fetch_pc = 32'd0; upd_valid = 1'b0; upd_pc = 32'd0;
    upd_taken = 1'b0; upd_target = 32'd0; flush = 1'b0;
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();
    model_reset();

    #2;
    chk("reset_pred_valid",  {31'd0, pred_valid},  32'd0);
    chk("reset_pred_hit",    {31'd0, pred_hit},    32'd0);
    chk("reset_pred_taken",  {31'd0, pred_taken},  32'd0);
    chk("reset_pred_target", pred_target,          32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //                fv  fpc         uv  upc         ut  utgt        fl   ev  eh  et  etgt
    vecs.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h00,  0,  1, 0, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h80,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h00,  0,  1, 1, 1, 32'h80));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h00,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h00,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h00,  0,  1, 1, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h80,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h80,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h80,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h00,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h00,  0,  1, 1, 1, 32'h80));
    vecs.push_back(mk(0, 32'h000, 1, 32'h140, 1, 32'h300, 0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h00,  0,  1, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h140, 0, 32'h000, 0, 32'h00,  0,  1, 1, 1, 32'h300));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h80,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h00,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h00,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h100, 1, 32'h100, 1, 32'h90,  0,  1, 1, 0, 32'h00));
    vecs.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h00,  0,  1, 1, 0, 32'h00));
    vecs.push_back(mk(1, 32'h103, 0, 32'h000, 0, 32'h00,  0,  1, 1, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h102, 1, 32'hA0,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h101, 0, 32'h000, 0, 32'h00,  0,  1, 1, 1, 32'hA0));
    vecs.push_back(mk(1, 32'h100, 1, 32'h200, 1, 32'h44,  1,  1, 1, 1, 32'hA0));
    vecs.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h00,  0,  1, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h200, 0, 32'h000, 0, 32'h00,  0,  1, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h140, 0, 32'h000, 0, 32'h00,  0,  1, 0, 0, 32'h00));
    vecs.push_back(mk(0, 32'h000, 1, 32'h200, 1, 32'h44,  0,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 32'h200, 0, 32'h000, 0, 32'h00,  0,  1, 1, 1, 32'h44));

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i]);
      chk($sformatf("vec%0d_valid", i),  {31'd0, pred_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_hit", i),    {31'd0, pred_hit},   {31'd0, vecs[i].eh});
      chk($sformatf("vec%0d_taken", i),  {31'd0, pred_taken}, {31'd0, vecs[i].et});
      chk($sformatf("vec%0d_target", i), pred_target,         vecs[i].etgt);
    end

    // Async reset in the middle of a prediction cycle, between clock edges.
    run_cycle(mk(1, 32'h200, 0, 32'h000, 0, 32'h00, 0, 1, 1, 1, 32'h44));
    chk("arst_pre_valid", {31'd0, pred_valid}, 32'd1);
    chk("arst_pre_hit",   {31'd0, pred_hit},   32'd1);
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid_drop",  {31'd0, pred_valid}, 32'd0);
    chk("arst_hit_drop",    {31'd0, pred_hit},   32'd0);
    chk("arst_target_drop", pred_target,         32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_cycle(mk(1, 32'h200, 0, 32'h000, 0, 32'h00, 0, 1, 0, 0, 32'h00));
    chk("arst_after_valid", {31'd0, pred_valid}, 32'd1);
    chk("arst_after_hit",   {31'd0, pred_hit},   32'd0);

    for (int n = 0; n < 3000; n++) begin
      rv.fv   = $urandom_range(0, 3) != 0;
      rv.fpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      rv.uv   = $urandom_range(0, 3) != 0;
      rv.upc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      rv.ut   = $urandom_range(0, 2) != 0;
      rv.utgt = $urandom;
      rv.fl   = $urandom_range(0, 63) == 0;
      run_cycle(rv);
      chk($sformatf("rnd%0d_valid", n),  {31'd0, pred_valid}, {31'd0, m_ev});
      chk($sformatf("rnd%0d_hit", n),    {31'd0, pred_hit},   {31'd0, m_eh});
      chk($sformatf("rnd%0d_taken", n),  {31'd0, pred_taken}, {31'd0, m_et});
      chk($sformatf("rnd%0d_target", n), pred_target,         m_etgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
